// File: rtl/bram_pkg.sv
// bram_pkg: shared types for the pipelined block RAM (rev 1.0).
`default_nettype none

package bram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } bram_state_e;

endpackage

`default_nettype wire

// File: rtl/bram_core.sv
// bram_core: byte-enabled synchronous array with optional output register (rev 1.0).
`default_nettype none

module bram_core
  import bram_pkg::*;
#(
  parameter int        ADDR_W   = 14,
  parameter int        SIZE     = 1 << ADDR_W,
  parameter int        DATA_L   = 4,
  parameter int        READ_LAT = 1,
  parameter rdw_mode_e RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic [DATA_L-1:0]   sel_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [8*DATA_L-1:0] wdata_i,
  output logic [8*DATA_L-1:0] rdata_o
);

  localparam int DATA_W = 8 * DATA_L;

  (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [SIZE];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] w_merged;

  always_comb begin
    w_merged = mem_q[addr_i];
    for (int i = 0; i < DATA_L; i++) begin
      if (sel_i[i]) w_merged[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < DATA_L; i++) begin
        if (sel_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rd_q <= (RDW_MODE == RDW_WRITE_FIRST) ? w_merged : mem_q[addr_i];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_out_reg
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk) out_q <= rd_q;
      assign rdata_o = out_q;
    end else begin : g_no_out_reg
      assign rdata_o = rd_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pipelined_bram.sv
// pipelined_bram: handshaked byte-enabled RAM with credit-limited response FIFO and clear engine (rev 1.0).
`default_nettype none

module pipelined_bram
  import bram_pkg::*;
#(
  parameter int        ADDR_W         = 14,
  parameter int        SIZE           = 1 << ADDR_W,
  parameter int        DATA_L         = 4,
  parameter int        READ_LAT       = 1,
  parameter rdw_mode_e RDW_MODE       = RDW_READ_FIRST,
  parameter int        CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [8*DATA_L-1:0] req_wdata,
  input  logic [DATA_L-1:0]   req_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*DATA_L-1:0] rsp_data,
  input  logic                clear_req,
  output logic                clear_busy
);

  localparam int                 DATA_W       = 8 * DATA_L;
  localparam int                 RSP_DEPTH    = READ_LAT + 1;
  localparam int                 CNT_W        = $clog2(RSP_DEPTH + 1);
  localparam int                 PTR_W        = $clog2(RSP_DEPTH);
  localparam logic [CNT_W-1:0]   FULL_CREDITS = CNT_W'(RSP_DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_ADDR    = ADDR_W'(SIZE - 1);
  localparam logic [PTR_W-1:0]   LAST_PTR     = PTR_W'(RSP_DEPTH - 1);

  bram_state_e         state_q;
  logic                active_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [READ_LAT-1:0] vpipe_q;
  logic [READ_LAT-1:0] vpipe_d;
  logic [CNT_W-1:0]    credits_q, credits_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0]   fifo_q [RSP_DEPTH];

  logic                w_accept, w_clearing, w_arrive, w_pop, w_fifo_pop, w_push;
  logic [DATA_W-1:0]   w_core_rdata;

  assign req_ready  = active_q && (state_q == S_RUN) && (credits_q != '0);
  assign w_accept   = req_valid && req_ready;
  assign w_clearing = (state_q == S_CLEAR);
  assign clear_busy = (state_q != S_RUN);

  // Array data bypasses the FIFO when nothing older is waiting.
  assign w_arrive   = vpipe_q[READ_LAT-1];
  assign rsp_valid  = (fifo_cnt_q != '0) || w_arrive;
  assign rsp_data   = ((fifo_cnt_q == '0) && w_arrive) ? w_core_rdata : fifo_q[rd_ptr_q];
  assign w_pop      = rsp_valid && rsp_ready;
  assign w_fifo_pop = w_pop && (fifo_cnt_q != '0);
  assign w_push     = w_arrive && !(w_pop && (fifo_cnt_q == '0));

  bram_core #(
    .ADDR_W  (ADDR_W),
    .SIZE    (SIZE),
    .DATA_L  (DATA_L),
    .READ_LAT(READ_LAT),
    .RDW_MODE(RDW_MODE)
  ) u_core (
    .clk    (clk),
    .en_i   (w_accept || w_clearing),
    .sel_i  (w_clearing ? {DATA_L{1'b1}} : req_sel),
    .addr_i (w_clearing ? clr_addr_q : req_addr),
    .wdata_i(w_clearing ? {DATA_W{1'b0}} : req_wdata),
    .rdata_o(w_core_rdata)
  );

  generate
    if (READ_LAT == 1) begin : g_vpipe_1
      assign vpipe_d = w_accept;
    end else begin : g_vpipe_n
      assign vpipe_d = {vpipe_q[READ_LAT-2:0], w_accept};
    end
  endgenerate

  always_comb begin
    credits_d = credits_q;
    if (w_accept && !w_pop)      credits_d = credits_q - 1'b1;
    else if (!w_accept && w_pop) credits_d = credits_q + 1'b1;
    fifo_cnt_d = fifo_cnt_q;
    if (w_push && !w_fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!w_push && w_fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      active_q   <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        S_RUN:   if (clear_req) state_q <= S_DRAIN;
        S_DRAIN: if ((vpipe_q == '0) && (fifo_cnt_q == '0)) state_q <= S_CLEAR;
        S_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            clr_addr_q <= '0;
            state_q    <= S_RUN;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q    <= '0;
      credits_q  <= FULL_CREDITS;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      vpipe_q    <= vpipe_d;
      credits_q  <= credits_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (w_push) begin
        fifo_q[wr_ptr_q] <= w_core_rdata;
        wr_ptr_q         <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_fifo_pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_bram.sv
// tb_pipelined_bram: directed self-checking bench for pipelined_bram (READ_LAT=2, READ_FIRST, SIZE=16).
`default_nettype none

module tb_pipelined_bram;
  import bram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        clear_req, clear_busy;

  int errors = 0;
  int checks = 0;

  logic [3:0]  s_addr [16];
  logic [31:0] s_wd   [16];
  logic [3:0]  s_sel  [16];
  logic [31:0] s_exp  [16];

  pipelined_bram #(
    .ADDR_W(4), .SIZE(16), .DATA_L(4), .READ_LAT(2),
    .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after rst_n release at a negedge: 16 clear cycles, then ready.
  task automatic wait_clear();
    for (int i = 0; i < 16; i++) begin
      check("clr_ready_low", {31'b0, req_ready}, 32'd0);
      check("clr_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check("clr_ready_high", {31'b0, req_ready}, 32'd1);
    check("clr_busy_low", {31'b0, clear_busy}, 32'd0);
  endtask

  task automatic single(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] sel,
                        output logic [31:0] rd);
    int n;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_sel = sel;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("single_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    rd = rsp_data;
    @(negedge clk);
  endtask

  // Back-to-back issue of s_* entries with rsp_ready=1; responses at negedge c+2.
  task automatic stream(input int n);
    int got = 0;
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) check("stream_ready", {31'b0, req_ready}, 32'd1);
      check("stream_valid", {31'b0, rsp_valid}, (c >= 2 && c < n + 2) ? 32'd1 : 32'd0);
      if (rsp_valid && got < n) begin
        check("stream_data", rsp_data, s_exp[got]);
        got++;
      end
      req_valid = (c < n);
      if (c < n) begin
        req_addr = s_addr[c]; req_wdata = s_wd[c]; req_sel = s_sel[c];
      end
      @(negedge clk);
    end
    check("stream_count", got, n);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] got_q [8];
    int got, busy;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
    rsp_ready = 1'b1; clear_req = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_clear_busy", {31'b0, clear_busy}, 32'd1);
    rst_n = 1'b1;
    wait_clear();

    for (int i = 0; i < 16; i++) begin
      single(4'(i), 32'h0, 4'b0000, rd);
      check("post_clear_read", rd, 32'h0);
    end

    single(4'd5, 32'hAABBCCDD, 4'b1111, rd);
    check("wr1_old", rd, 32'h0);
    single(4'd5, 32'h11223344, 4'b0101, rd);
    check("wr2_read_first", rd, 32'hAABBCCDD);
    single(4'd5, 32'h0, 4'b0000, rd);
    check("merged_read", rd, 32'hAA22CC44);

    for (int i = 0; i < 8; i++) begin
      single(4'(i), 32'hA0000000 | i, 4'b1111, rd);
      check("fill_old", rd, (i == 5) ? 32'hAA22CC44 : 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      s_addr[i] = 4'(i); s_wd[i] = 32'h0; s_sel[i] = 4'b0000; s_exp[i] = 32'hA0000000 | i;
    end
    stream(8);

    s_addr[0] = 4'd9; s_wd[0] = 32'h12345678; s_sel[0] = 4'b1111; s_exp[0] = 32'h0;
    s_addr[1] = 4'd9; s_wd[1] = 32'h0;        s_sel[1] = 4'b0000; s_exp[1] = 32'h12345678;
    s_addr[2] = 4'd9; s_wd[2] = 32'hFF000000; s_sel[2] = 4'b1000; s_exp[2] = 32'h12345678;
    s_addr[3] = 4'd9; s_wd[3] = 32'h0;        s_sel[3] = 4'b0000; s_exp[3] = 32'hFF345678;
    stream(4);

    // Backpressure: three accepts fill the credits, head data holds.
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) check("bp_ready_high", {31'b0, req_ready}, 32'd1);
      else       check("bp_ready_low", {31'b0, req_ready}, 32'd0);
      if (c >= 2) begin
        check("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
        check("bp_data_hold", rsp_data, 32'hA0000000);
      end
      req_valid = (c < 3); req_addr = 4'(c); req_sel = 4'b0000;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid && got < 8) begin got_q[got] = rsp_data; got++; end
      @(negedge clk);
    end
    check("bp_count", got, 3);
    for (int k = 0; k < 3; k++) check("bp_order", got_q[k], 32'hA0000000 | k);

    // Clear with two reads in flight.
    req_valid = 1'b1; req_addr = 4'd0; req_sel = 4'b0000;
    @(negedge clk);
    req_addr = 4'd1; clear_req = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; clear_req = 1'b0;
    check("drain_ready_low", {31'b0, req_ready}, 32'd0);
    got = 0; busy = 0;
    while (clear_busy && busy < 100) begin
      if (rsp_valid && got < 8) begin got_q[got] = rsp_data; got++; end
      busy++;
      @(negedge clk);
    end
    check("clear_busy_cycles", busy, 19);
    check("drain_count", got, 2);
    check("drain_rsp0", got_q[0], 32'hA0000000);
    check("drain_rsp1", got_q[1], 32'hA0000001);
    for (int i = 0; i < 16; i++) begin
      single(4'(i), 32'h0, 4'b0000, rd);
      check("after_clear_read", rd, 32'h0);
    end

    // Reset mid-stream, then reset mid-clear.
    single(4'd0, 32'hDEADBEEF, 4'b1111, rd);
    single(4'd15, 32'hCAFEF00D, 4'b1111, rd);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 4'd0; req_sel = 4'b0000;
    @(negedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("async_rst_data", rsp_data, 32'd0);
    check("async_rst_ready", {31'b0, req_ready}, 32'd0);
    check("async_rst_busy", {31'b0, clear_busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("mid_clear_no_rsp", {31'b0, rsp_valid}, 32'd0);
      check("mid_clear_busy", {31'b0, clear_busy}, 32'd1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    wait_clear();
    single(4'd15, 32'h0, 4'b0000, rd);
    check("rst_clear_addr15", rd, 32'h0);
    single(4'd0, 32'h0, 4'b0000, rd);
    check("rst_clear_addr0", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
